// File: rtl/tick_rate_pkg.sv
// rtl/tick_rate_pkg.sv - shared mode type, default rates and mode sequencing for tick_rate_ctrl
package tick_rate_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_MINUTE = 2'd1,
    MODE_HOUR   = 2'd2
  } mode_t;

  localparam int unsigned     ACC_W_DEF      = 40;
  localparam longint unsigned INC_NORMAL_DEF = 64'd21990;
  localparam longint unsigned INC_MINUTE_DEF = 64'd1319414;
  localparam longint unsigned INC_HOUR_DEF   = 64'd79164837;
  localparam int unsigned     SCAN_W_DEF     = 16;

  // NORMAL -> MINUTE -> HOUR -> NORMAL
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_NORMAL: next_mode = MODE_MINUTE;
      MODE_MINUTE: next_mode = MODE_HOUR;
      default:     next_mode = MODE_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/tick_rate_ctrl_if.sv
// rtl/tick_rate_ctrl_if.sv - control and enable signals between tick_rate_ctrl and its user
interface tick_rate_ctrl_if;
  import tick_rate_pkg::*;

  logic       run;
  logic       mode_set;
  logic [1:0] mode_req;
  logic       mode_step;
  logic       tick;
  logic       scan_tick;
  mode_t      mode;
  logic       pending;
  logic       mode_ack;

  modport master (
    output run, mode_set, mode_req, mode_step,
    input  tick, scan_tick, mode, pending, mode_ack
  );

  modport slave (
    input  run, mode_set, mode_req, mode_step,
    output tick, scan_tick, mode, pending, mode_ack
  );

endinterface

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running power-of-two divider producing a one-cycle scan enable
module scan_tick_gen #(
  parameter int unsigned SCAN_W = 16
) (
  input  logic clk,
  input  logic reset,
  output logic scan_tick
);

  logic [SCAN_W-1:0] cnt_q, cnt_d;
  logic              scan_q, scan_d;

  always_comb begin
    cnt_d  = cnt_q + SCAN_W'(1);
    scan_d = &cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      scan_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
    end
  end

  assign scan_tick = scan_q;

endmodule

// File: rtl/tick_rate_ctrl.sv
// rtl/tick_rate_ctrl.sv - phase-accumulator tick generator with boundary-aligned rate switching
module tick_rate_ctrl
  import tick_rate_pkg::*;
#(
  parameter int unsigned     ACC_W      = ACC_W_DEF,
  parameter longint unsigned INC_NORMAL = INC_NORMAL_DEF,
  parameter longint unsigned INC_MINUTE = INC_MINUTE_DEF,
  parameter longint unsigned INC_HOUR   = INC_HOUR_DEF,
  parameter int unsigned     SCAN_W     = SCAN_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  tick_rate_ctrl_if.slave bus
);

  if (INC_NORMAL >= (64'd1 << ACC_W) || INC_MINUTE >= (64'd1 << ACC_W) ||
      INC_HOUR >= (64'd1 << ACC_W)) begin : g_inc_range
    $error("tick_rate_ctrl: every increment must be below 2**ACC_W");
  end

  localparam logic [ACC_W-1:0] INC_N = ACC_W'(INC_NORMAL);
  localparam logic [ACC_W-1:0] INC_M = ACC_W'(INC_MINUTE);
  localparam logic [ACC_W-1:0] INC_H = ACC_W'(INC_HOUR);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             pend_q, pend_d;
  mode_t            mode_q, mode_d;
  mode_t            pmode_q, pmode_d;

  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             req_v;
  mode_t            req_mode;
  logic             scan_tick_w;

  // Reserved mode_req=3 falls through so a simultaneous step still counts.
  always_comb begin
    req_v    = 1'b0;
    req_mode = mode_q;
    if (bus.mode_set && bus.mode_req != 2'd3) begin
      req_v    = 1'b1;
      req_mode = mode_t'(bus.mode_req);
    end else if (bus.mode_step) begin
      req_v    = 1'b1;
      req_mode = next_mode(pend_q ? pmode_q : mode_q);
    end
  end

  always_comb begin
    case (mode_q)
      MODE_MINUTE: inc = INC_M;
      MODE_HOUR:   inc = INC_H;
      default:     inc = INC_N;
    endcase
    sum   = {1'b0, acc_q} + {1'b0, inc};
    carry = bus.run & sum[ACC_W];
  end

  always_comb begin
    acc_d   = bus.run ? sum[ACC_W-1:0] : acc_q;
    tick_d  = carry;
    mode_d  = mode_q;
    pmode_d = pmode_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    if (!bus.run) begin
      // Stopped: no tick interval to protect, so switch immediately.
      if (req_v) begin
        mode_d  = req_mode;
        pmode_d = req_mode;
        pend_d  = 1'b0;
        ack_d   = 1'b1;
      end else if (pend_q) begin
        mode_d = pmode_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else begin
      // The carrying add used the old rate; a same-cycle request waits for the next carry.
      if (carry && pend_q) begin
        mode_d = pmode_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
      if (req_v) begin
        pend_d  = 1'b1;
        pmode_d = req_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      mode_q  <= MODE_NORMAL;
      pmode_q <= MODE_NORMAL;
    end else begin
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      pmode_q <= pmode_d;
    end
  end

  scan_tick_gen #(
    .SCAN_W(SCAN_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .scan_tick(scan_tick_w)
  );

  assign bus.tick      = tick_q;
  assign bus.mode_ack  = ack_q;
  assign bus.pending   = pend_q;
  assign bus.mode      = mode_q;
  assign bus.scan_tick = scan_tick_w;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// tb/tb_tick_rate_ctrl.sv - directed and randomized checks of tick_rate_ctrl against a rate model
module tb_tick_rate_ctrl;
  import tick_rate_pkg::*;

  localparam int MODULUS = 256;
  localparam int SCAN_P  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tick_rate_ctrl_if bus();

  tick_rate_ctrl #(
    .ACC_W     (8),
    .INC_NORMAL(64'd1),
    .INC_MINUTE(64'd4),
    .INC_HOUR  (64'd16),
    .SCAN_W    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase in [0,256), rate per mode, one pending slot.
  int cyc = 0;
  bit mvalid = 0;
  int m_phase, m_mode, m_pend, m_pm, m_req, m_s;
  bit m_rv;
  bit e_tick, e_ack;

  function automatic int rate_of(input int m);
    return (m == 2) ? 16 : (m == 1) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mvalid = 1; cyc = 1;
      m_phase = 0; m_mode = 0; m_pend = 0; m_pm = 0;
      e_tick = 0; e_ack = 0;
    end else if (mvalid) begin
      cyc++;
      e_tick = 0; e_ack = 0;
      m_rv = 0; m_req = 0;
      if (bus.mode_set && bus.mode_req != 2'd3) begin
        m_rv = 1; m_req = int'(bus.mode_req);
      end else if (bus.mode_step) begin
        m_rv = 1; m_req = ((m_pend != 0 ? m_pm : m_mode) + 1) % 3;
      end
      if (!bus.run) begin
        if (m_rv) begin
          m_mode = m_req; m_pm = m_req; m_pend = 0; e_ack = 1;
        end else if (m_pend != 0) begin
          m_mode = m_pm; m_pend = 0; e_ack = 1;
        end
      end else begin
        m_s = m_phase + rate_of(m_mode);
        if (m_s >= MODULUS) begin
          e_tick = 1;
          m_s -= MODULUS;
          if (m_pend != 0) begin
            m_mode = m_pm; m_pend = 0; e_ack = 1;
          end
        end
        m_phase = m_s;
        if (m_rv) begin
          m_pend = 1; m_pm = m_req;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("tick", 32'(bus.tick), 32'(e_tick));
      chk("mode_ack", 32'(bus.mode_ack), 32'(e_ack));
      chk("pending", 32'(bus.pending), 32'(m_pend));
      chk("mode", 32'(bus.mode), 32'(m_mode));
      chk("scan_tick", 32'(bus.scan_tick), 32'((cyc > 1) && ((cyc - 1) % SCAN_P == 0)));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b0; bus.mode_set = 1'b0; bus.mode_step = 1'b0; bus.mode_req = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic goto(input int c);
    int n = 0;
    while (cyc < c && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      checks++; failures++;
      $display("FAIL goto got=%0d exp=%0d", cyc, c);
    end
  endtask

  int acks;
  int ticks;

  initial begin
    bus.run = 1'b0; bus.mode_set = 1'b0; bus.mode_step = 1'b0; bus.mode_req = 2'd0;

    // NORMAL rate from reset
    do_reset();
    bus.run = 1'b1;
    goto(17);  chk("s1_scan17", 32'(bus.scan_tick), 1);
    goto(256); chk("s1_tick256", 32'(bus.tick), 0);
    goto(257); chk("s1_tick257", 32'(bus.tick), 1);
    chk("s1_mode", 32'(bus.mode), 0);
    chk("s1_pend", 32'(bus.pending), 0);
    goto(513); chk("s1_tick513", 32'(bus.tick), 1);

    // switch to HOUR waits for the carry
    do_reset();
    bus.run = 1'b1;
    goto(10); bus.mode_req = 2'd2; bus.mode_set = 1'b1;
    goto(11); bus.mode_set = 1'b0;
    chk("s2_pend11", 32'(bus.pending), 1);
    goto(256); chk("s2_pend256", 32'(bus.pending), 1);
    goto(257); chk("s2_tick257", 32'(bus.tick), 1);
    chk("s2_ack257", 32'(bus.mode_ack), 1);
    chk("s2_mode257", 32'(bus.mode), 2);
    chk("s2_pend257", 32'(bus.pending), 0);
    goto(272); chk("s2_tick272", 32'(bus.tick), 0);
    goto(273); chk("s2_tick273", 32'(bus.tick), 1);
    goto(289); chk("s2_tick289", 32'(bus.tick), 1);

    // three steps collapse into one ack
    do_reset();
    bus.run = 1'b1;
    goto(5); bus.mode_step = 1'b1;
    goto(8); bus.mode_step = 1'b0;
    goto(256); chk("s3_pend256", 32'(bus.pending), 1);
    acks = 0;
    while (cyc < 400) begin
      @(negedge clk);
      acks += int'(bus.mode_ack);
    end
    chk("s3_acks", 32'(acks), 1);
    chk("s3_mode", 32'(bus.mode), 0);

    // set beats step; reserved request ignored
    do_reset();
    bus.run = 1'b1;
    goto(20); bus.mode_req = 2'd1; bus.mode_set = 1'b1; bus.mode_step = 1'b1;
    goto(21); bus.mode_set = 1'b0; bus.mode_step = 1'b0;
    goto(30); bus.mode_req = 2'd3; bus.mode_set = 1'b1;
    goto(31); bus.mode_set = 1'b0;
    chk("s4_pend31", 32'(bus.pending), 1);
    goto(257); chk("s4_mode", 32'(bus.mode), 1);
    chk("s4_ack", 32'(bus.mode_ack), 1);

    // stopped: immediate switch, no ticks
    do_reset();
    bus.run = 1'b0;
    goto(3); bus.mode_req = 2'd1; bus.mode_set = 1'b1;
    goto(4); bus.mode_set = 1'b0;
    chk("s5_mode4", 32'(bus.mode), 1);
    chk("s5_ack4", 32'(bus.mode_ack), 1);
    chk("s5_pend4", 32'(bus.pending), 0);
    ticks = 0;
    while (cyc < 300) begin
      @(negedge clk);
      ticks += int'(bus.tick);
    end
    chk("s5_ticks", 32'(ticks), 0);

    // reset in HOUR with a change pending
    do_reset();
    bus.run = 1'b1;
    goto(2); bus.mode_req = 2'd2; bus.mode_set = 1'b1;
    goto(3); bus.mode_set = 1'b0;
    goto(257); chk("s6_mode_hour", 32'(bus.mode), 2);
    goto(260); bus.mode_req = 2'd1; bus.mode_set = 1'b1;
    goto(261); bus.mode_set = 1'b0;
    chk("s6_pend", 32'(bus.pending), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s6_mode_rst", 32'(bus.mode), 0);
    chk("s6_pend_rst", 32'(bus.pending), 0);
    goto(256); chk("s6_tick256", 32'(bus.tick), 0);
    goto(257); chk("s6_tick257", 32'(bus.tick), 1);
    chk("s6_ack257", 32'(bus.mode_ack), 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 1499) == 0);
      bus.run       = ($urandom_range(0, 9) != 0);
      bus.mode_set  = ($urandom_range(0, 39) == 0);
      bus.mode_req  = 2'($urandom_range(0, 3));
      bus.mode_step = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    reset = 1'b0; bus.mode_set = 1'b0; bus.mode_step = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_rate_ctrl.md
Name: tick_rate_ctrl

Overview:
Controls the timekeeping rate of the water-reminder clock. It owns one phase accumulator and emits a single-cycle tick enable at one of three selectable rates:
- NORMAL: 1 tick = 1 s
- MINUTE: 60 ticks/s, demo speed-up
- HOUR: 3600 ticks/s

Rate changes are applied only at a tick boundary, so no tick interval is ever shortened. The block also emits a free-running display-scan enable. Downstream time counters and display muxes run on clk, gated by these enables; there are no derived clocks.

Parameters:
ACC_W, 40, accumulator width.
INC_NORMAL, 21990, increment for NORMAL (2^40/50 MHz ≈ 1 Hz).
INC_MINUTE, 1319414, increment for MINUTE (≈60 Hz).
INC_HOUR, 79164837, increment for HOUR (≈3600 Hz).
SCAN_W, 16, scan divider width (scan tick every 2^SCAN_W cycles, ≈763 Hz).

Ports:
clk  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high.
run  in  1  1 = accumulate; 0 = hold accumulator, no ticks.
mode_set  in  1  one-cycle request to load mode_req.
mode_req  in  2  requested mode: 0 NORMAL, 1 MINUTE, 2 HOUR, 3 reserved.
mode_step  in  1  one-cycle request to advance NORMAL→MINUTE→HOUR→NORMAL. Already debounced upstream.
tick  out  1  one-cycle rate enable.
scan_tick  out  1  one-cycle display-scan enable.
mode  out  2  currently active mode.
pending  out  1  a mode change is waiting for a tick boundary.
mode_ack  out  1  one-cycle pulse when a pending mode becomes active.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on posedge clk, and overrides all other inputs.
- Reset values:
  - acc=0, scan counter=0
  - tick=0, scan_tick=0, mode_ack=0, pending=0
  - mode=NORMAL, pending mode=NORMAL
- Accumulator:
  - When run=1, each cycle computes {carry, acc_next} = acc + inc(mode) in ACC_W+1 bits and sets acc ← acc_next.
  - The increment is zero-extended to ACC_W bits.
  - tick is registered: tick=1 in the cycle after an add with carry=1, otherwise 0. Latency is 1 cycle.
  - When run=0, acc holds and tick=0.
- Mode request capture, in priority order each cycle:
  - mode_set with mode_req ∈ {0,1,2}: pending ← 1, pending mode ← mode_req.
  - mode_set with mode_req=3: ignored. If mode_step is also high, mode_step is processed instead.
  - mode_step alone: pending ← 1, pending mode ← successor of (pending ? pending mode : mode).
  - mode_set and mode_step in the same cycle: mode_set wins.
  - A new request while pending=1 overwrites the pending mode; the latest request wins and only one ack is issued.
  - A request equal to the active mode is still pended and acked.
- Apply rule:
  - When run=1: a pending change applies on the edge where the add produces carry=1 (that add still uses the old increment). On that edge: mode ← pending mode, pending ← 0, and mode_ack=1 in the same cycle as the resulting tick.
  - The accumulator is NOT cleared on a mode change, so phase stays continuous.
  - When run=0: the pending change applies on the next edge, with mode_ack pulsing one cycle after the request; there is no boundary to protect.
  - A request arriving in the same cycle as a carry is captured but not applied until the next carry; the carry applies the previously pending value, if any.
- Scan divider:
  - A SCAN_W-bit counter increments every cycle, independent of run and mode.
  - scan_tick is registered: it is 1 in the cycle after the counter wraps from all-ones to 0, giving period 2^SCAN_W cycles.
- Reset mid-operation clears everything, including pending, on the same edge. The first tick after reset occurs ceil(2^ACC_W / inc) + 1 cycles after reset deasserts.
- Width rule: the increment must be less than 2^ACC_W. This is checked by an elaboration-time assertion.

Decomposition:
- tick_rate_pkg:
  - mode_t enum {MODE_NORMAL=2'd0, MODE_MINUTE=2'd1, MODE_HOUR=2'd2}
  - default INC_* constants
  - successor function next_mode(mode_t)
- Sub-module scan_tick_gen (parameter SCAN_W; ports clk, reset, scan_tick): a fixed divider, reused by the display block.

Test Plan:
All scenarios use the overrides ACC_W=8, INC_NORMAL=1, INC_MINUTE=4, INC_HOUR=16, SCAN_W=4.
- Reset, then run=1 for 600 cycles → first tick at cycle 257, then exactly every 256 cycles; mode=0; pending=0; scan_tick every 16 cycles from cycle 17.
- Reset, mode_set with mode_req=2 at cycle 10 → pending=1 until the carry at cycle 256; tick and mode_ack at 257; mode=2; subsequent ticks every 16 cycles (273, 289, ...).
- Reset, then mode_step ×3 at cycles 5, 6, 7 → pending mode sequence 1, 2, 0; one mode_ack at cycle 257; mode=0.
- Reset, then mode_set(1) and mode_step in the same cycle at cycle 20 → pending mode=1. mode_set(3) alone at cycle 30 → no change, pending mode stays 1.
- Reset, run=0, mode_set(1) at cycle 3 → mode=1 and mode_ack at cycle 4; acc unchanged; no tick while run=0.
- In HOUR mode, assert reset for 1 cycle between ticks while pending=1 → next cycle mode=0, pending=0, acc=0; no tick or ack until 257 cycles after release.
